uart_rx_port: RTL and testbench

UART_RX_PORT -- requirements
Module: uart_rx_port

---
 rtl/uart_rx_port_pkg.sv | 16 +
 rtl/tick_gen.sv | 34 +++
 rtl/uart_rx_port.sv | 136 +++++++++++++
 tb/tb_uart_rx_port.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_port_pkg.sv
// Shared UART receiver definitions: state encoding and frame timing constants.
package uart_rx_port_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  localparam int unsigned OversampleTicks = 16;
  localparam int unsigned MidTick         = 7;
  localparam int unsigned DataBits        = 8;

endpackage

// File: rtl/tick_gen.sv
// Oversample prescaler: one-cycle tick every clk_div cycles while enabled, held at 0 otherwise.
module tick_gen #(
  parameter int unsigned clk_div = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] LastCnt = 16'(clk_div - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || cnt_q == LastCnt) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with 16x oversampling; delivers each good byte as a one-cycle port write.
module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int unsigned clk_div    = 27,
  parameter bit          stop_check = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] port_in,
  output logic       port_write,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] LastTick = 4'(OversampleTicks - 1);
  localparam logic [3:0] MidCnt   = 4'(MidTick);
  localparam logic [2:0] LastBit  = 3'(DataBits - 1);

  rx_state_e   state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  port_in_q, port_in_d;
  logic        port_write_q, port_write_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;
  logic        tick;

  tick_gen #(
    .clk_div(clk_div)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .enable(state_q != StIdle),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    tick_cnt_d   = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    port_in_d    = port_in_q;
    port_write_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tick_cnt_d = 4'd0;
        bit_cnt_d  = 3'd0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        // Mid-start sample rejects glitches shorter than half a bit.
        if (tick && tick_cnt_q == MidCnt) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d    = StData;
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
          end
        end
      end
      StData: begin
        if (tick && tick_cnt_q == LastTick) begin
          shift_d[bit_cnt_q] = rx_s_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick && tick_cnt_q == LastTick) begin
          if (rx_s_q || !stop_check) begin
            port_in_d    = shift_q;
            port_write_d = 1'b1;
            state_d      = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      port_in_q    <= 8'h00;
      port_write_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      port_in_q    <= port_in_d;
      port_write_q <= port_write_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign port_in    = port_in_q;
  assign port_write = port_write_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Scoreboard bench for uart_rx_port at clk_div=1 (16 cycles per bit), stop_check on and off.
module tb_uart_rx_port;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line = 1'b1;
  int   sel = 0;
  logic rx0, rx1;
  logic [7:0] pi0, pi1;
  logic pw0, pw1, fe0, fe1, busy0, busy1;

  assign rx0 = (sel == 0) ? line : 1'b1;
  assign rx1 = (sel == 1) ? line : 1'b1;

  uart_rx_port #(
    .clk_div   (1),
    .stop_check(1'b1)
  ) dut0 (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx0),
    .port_in   (pi0),
    .port_write(pw0),
    .frame_err (fe0),
    .busy      (busy0)
  );

  uart_rx_port #(
    .clk_div   (1),
    .stop_check(1'b0)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx1),
    .port_in   (pi1),
    .port_write(pw1),
    .frame_err (fe1),
    .busy      (busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pw_cyc0 = -1;
  int   pw_cyc1 = -1;
  logic [7:0] model0 = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Pops an expected event for every strobe seen on either receiver.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (pw0 || fe0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe0: got pw=%b fe=%b port_in=%h, required no strobe",
                   pw0, fe0, pi0);
        end else begin
          e = q0.pop_front();
          if (pw0 !== !e.is_err || fe0 !== e.is_err || pi0 !== e.data) begin
            errors++;
            $display("FAIL strobe0: got pw=%b fe=%b port_in=%h, required pw=%b fe=%b port_in=%h",
                     pw0, fe0, pi0, !e.is_err, e.is_err, e.data);
          end
        end
        if (pw0) pw_cyc0 = cyc;
      end
      if (pw1 || fe1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe1: got pw=%b fe=%b port_in=%h, required no strobe",
                   pw1, fe1, pi1);
        end else begin
          e = q1.pop_front();
          if (pw1 !== !e.is_err || fe1 !== e.is_err || pi1 !== e.data) begin
            errors++;
            $display("FAIL strobe1: got pw=%b fe=%b port_in=%h, required pw=%b fe=%b port_in=%h",
                     pw1, fe1, pi1, !e.is_err, e.is_err, e.data);
          end
        end
        if (pw1) pw_cyc1 = cyc;
      end
    end
  end

  // Drives one 8N1 frame on the selected receiver and queues the outcome it should produce.
  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    exp_t e;
    if (sel == 0) begin
      if (stop_v) begin
        e.is_err = 1'b0;
        e.data   = d;
        model0   = d;
      end else begin
        e.is_err = 1'b1;
        e.data   = model0;
      end
      q0.push_back(e);
    end else begin
      e.is_err = 1'b0;
      e.data   = d;
      q1.push_back(e);
    end
    line = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      repeat (16) @(negedge clk);
    end
    line = stop_v;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    line  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pi0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_port_in: got %h, required 00", pi0);
    end
    checks++;
    if (pw0 !== 1'b0 || fe0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got pw=%b fe=%b, required 0 0", pw0, fe0);
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b %b, required 0 0", busy0, busy1);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int c0;
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL good_frame_seen: got %0d pending, required 0", q0.size());
    end
    // Two synchronizer cycles plus 152*clk_div+1.
    checks++;
    if (pw_cyc0 - c0 != 155) begin
      errors++;
      $display("FAIL good_frame_latency: got %0d cycles, required 155", pw_cyc0 - c0);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL good_frame_idle: got busy=%b, required 0", busy0);
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL frame_err_seen: got %0d pending, required 0", q0.size());
    end
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle_busy: got busy=%b, required 1", busy0);
    end
    checks++;
    if (pi0 !== model0) begin
      errors++;
      $display("FAIL frame_err_hold: got port_in=%h, required %h", pi0, model0);
    end
    line = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle_exit: got busy=%b, required 0", busy0);
    end
  endtask

  task automatic test_glitch();
    line = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: got busy=%b, required 1", busy0);
    end
    line = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: got busy=%b, required 0", busy0);
    end
    checks++;
    if (pi0 !== model0) begin
      errors++;
      $display("FAIL glitch_hold: got port_in=%h, required %h", pi0, model0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      send_frame(r, 1'b1);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d pending, required 0", q0.size());
    end
    checks++;
    if (pi0 !== model0) begin
      errors++;
      $display("FAIL back_to_back_last: got port_in=%h, required %h", pi0, model0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d    = 8'h81;
    line = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      line = d[i];
      repeat (16) @(negedge clk);
    end
    line = d[3];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    line  = 1'b1;
    repeat (3) @(negedge clk);
    model0 = 8'h00;
    checks++;
    if (busy0 !== 1'b0 || pi0 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_state: got busy=%b port_in=%h, required 0 00", busy0, pi0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h42, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL after_reset_frame: got %0d pending, required 0", q0.size());
    end
    checks++;
    if (pi0 !== 8'h42) begin
      errors++;
      $display("FAIL after_reset_value: got port_in=%h, required 42", pi0);
    end
  endtask

  task automatic test_no_stop_check();
    int c1;
    sel = 1;
    c1  = cyc;
    send_frame(8'hA5, 1'b0);
    line = 1'b1;
    sel  = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL no_stop_check_seen: got %0d pending, required 0", q1.size());
    end
    checks++;
    if (pw_cyc1 - c1 != 155) begin
      errors++;
      $display("FAIL no_stop_check_latency: got %0d cycles, required 155", pw_cyc1 - c1);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL no_stop_check_idle: got busy=%b, required 0", busy1);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_stop_check();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
